detect_window_monitor: RTL and testbench

Downstream consumer of the serial sequence detector's `detected` output. It counts detection pulses over a programmable window of clock cycles and publishes each window's count through a valid/ready handshake. It also flags windows whose count reaches a threshold, and records a sticky overrun when a result cannot be delivered.

---
 rtl/detect_window_monitor.sv | 146 ++++++++++++++
 tb/tb_detect_window_monitor.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/detect_window_monitor.sv
// ---------------------------------------------------------------------------
// detect_window_monitor
//
// Counts detection pulses from a serial sequence detector over a programmable
// window of clock cycles. Each completed window's count is published through a
// valid/ready handshake. A window whose count reaches the threshold raises the
// alarm flag. A result that cannot be delivered is discarded and flagged by a
// sticky overrun bit.
//
// Parameters
//   CNT_W          width of the event count and of the threshold
//   WIN_W          width of the window length
//
// Ports
//   clk            single clock, rising edge
//   reset          asynchronous, active-low reset
//   detected       detection pulse, sampled every cycle while counting
//   enable         run/stop; dropping it mid-window aborts that window
//   window_len     window length in cycles, sampled at window start (0 -> 1)
//   threshold      alarm threshold, sampled at window end
//   win_count      count of the last delivered-or-pending window (registered)
//   win_valid      win_count holds an undelivered result
//   win_ready      consumer accepts the result
//   alarm          last completed window count >= threshold
//   overrun        sticky: a completed window was discarded
//   clear_overrun  synchronous clear of overrun
// ---------------------------------------------------------------------------
module detect_window_monitor #(
    parameter int CNT_W = 8,
    parameter int WIN_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             detected,
    input  logic             enable,
    input  logic [WIN_W-1:0] window_len,
    input  logic [CNT_W-1:0] threshold,
    output logic [CNT_W-1:0] win_count,
    output logic             win_valid,
    input  logic             win_ready,
    output logic             alarm,
    output logic             overrun,
    input  logic             clear_overrun
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_COUNT = 1'b1
    } state_t;

    state_t           r_state;
    logic [WIN_W-1:0] r_len;        // latched window length, always >= 1
    logic [WIN_W-1:0] r_cyc;        // position inside the window, 0..len-1
    logic [CNT_W-1:0] r_evt;        // saturating event count of this window
    logic [CNT_W-1:0] r_win_count;
    logic             r_win_valid;
    logic             r_alarm;
    logic             r_overrun;

    logic [WIN_W-1:0] w_len_eff;
    logic [CNT_W-1:0] w_evt_next;
    logic             w_last;
    logic             w_can_load;

    // A zero length would never reach its end; treat it as a one-cycle window.
    assign w_len_eff  = (window_len == '0) ? WIN_W'(1) : window_len;

    // Saturating increment: the count sticks at all-ones instead of wrapping.
    // At window end this is also the final value, so the last-cycle pulse
    // is included.
    assign w_evt_next = (detected && (r_evt != '1)) ? r_evt + CNT_W'(1) : r_evt;

    assign w_last     = (r_cyc == (r_len - WIN_W'(1)));

    // The output register may take a new result if it is empty or is being
    // emptied by a transfer in this same cycle.
    assign w_can_load = !r_win_valid || win_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_len       <= WIN_W'(1);
            r_cyc       <= '0;
            r_evt       <= '0;
            r_win_count <= '0;
            r_win_valid <= 1'b0;
            r_alarm     <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            // Handshake: a transfer empties the output register unless a new
            // publish below refills it in the same cycle.
            if (r_win_valid && win_ready) begin
                r_win_valid <= 1'b0;
            end

            // Clear comes first so that a discard in the same cycle wins.
            if (clear_overrun) begin
                r_overrun <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (enable) begin
                        r_len   <= w_len_eff;
                        r_cyc   <= '0;
                        r_evt   <= '0;
                        r_state <= S_COUNT;
                    end
                end

                S_COUNT: begin
                    if (!enable) begin
                        // Abort: partial count is dropped, outputs untouched.
                        r_state <= S_IDLE;
                    end else if (w_last) begin
                        // Alarm tracks every completed window, delivered or not.
                        r_alarm <= (w_evt_next >= threshold);
                        if (w_can_load) begin
                            r_win_count <= w_evt_next;
                            r_win_valid <= 1'b1;
                        end else begin
                            r_overrun <= 1'b1;
                        end
                        // Next window begins immediately, no gap cycle.
                        r_len <= w_len_eff;
                        r_cyc <= '0;
                        r_evt <= '0;
                    end else begin
                        r_cyc <= r_cyc + WIN_W'(1);
                        r_evt <= w_evt_next;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign win_count = r_win_count;
    assign win_valid = r_win_valid;
    assign alarm     = r_alarm;
    assign overrun   = r_overrun;

endmodule

// File: tb/tb_detect_window_monitor.sv
// ---------------------------------------------------------------------------
// Self-checking bench for detect_window_monitor: a table of short vectors,
// hand-written multi-cycle sequences and a randomized run compared against a
// window-level reference model.
// ---------------------------------------------------------------------------
module tb_detect_window_monitor;

    localparam int CNT_W = 8;
    localparam int WIN_W = 16;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             detected = 1'b0;
    logic             enable = 1'b0;
    logic [WIN_W-1:0] window_len = '0;
    logic [CNT_W-1:0] threshold = '0;
    logic [CNT_W-1:0] win_count;
    logic             win_valid;
    logic             win_ready = 1'b0;
    logic             alarm;
    logic             overrun;
    logic             clear_overrun = 1'b0;

    detect_window_monitor #(.CNT_W(CNT_W), .WIN_W(WIN_W)) dut (
        .clk           (clk),
        .reset         (reset),
        .detected      (detected),
        .enable        (enable),
        .window_len    (window_len),
        .threshold     (threshold),
        .win_count     (win_count),
        .win_valid     (win_valid),
        .win_ready     (win_ready),
        .alarm         (alarm),
        .overrun       (overrun),
        .clear_overrun (clear_overrun)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // ---------------- reference model (window level) ----------------
    // A window is the list of detected samples seen while running; it closes
    // when the list reaches the latched length.
    bit m_run;
    int m_len;
    bit m_samples[$];
    bit m_valid;
    int m_count;
    bit m_alarm;
    bit m_overrun;

    function automatic void model_reset();
        m_run = 0; m_len = 1; m_samples.delete();
        m_valid = 0; m_count = 0; m_alarm = 0; m_overrun = 0;
    endfunction

    function automatic void model_edge(bit en, bit det, int wl, int thr, bit rdy, bit clr);
        bit had_valid;
        int sum;
        had_valid = m_valid;
        if (m_valid && rdy) m_valid = 0;
        if (clr) m_overrun = 0;
        if (!m_run) begin
            if (en) begin
                m_run = 1;
                m_len = (wl == 0) ? 1 : wl;
                m_samples.delete();
            end
        end else if (!en) begin
            m_run = 0;
            m_samples.delete();
        end else begin
            m_samples.push_back(det);
            if (m_samples.size() == m_len) begin
                sum = 0;
                foreach (m_samples[k]) sum += int'(m_samples[k]);
                if (sum > CNT_MAX) sum = CNT_MAX;
                m_alarm = (sum >= thr);
                if (!had_valid || rdy) begin
                    m_count = sum;
                    m_valid = 1;
                end else begin
                    m_overrun = 1;
                end
                m_samples.delete();
                m_len = (wl == 0) ? 1 : wl;
            end
        end
    endfunction

    // ---------------- helpers ----------------
    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Drive one cycle's inputs at the falling edge, advance past the rising
    // edge and update the model with the same inputs.
    task automatic step(input bit en, input bit det, input int wl, input int thr,
                        input bit rdy, input bit clr);
        @(negedge clk);
        enable = en; detected = det; window_len = WIN_W'(wl);
        threshold = CNT_W'(thr); win_ready = rdy; clear_overrun = clr;
        @(posedge clk);
        model_edge(en, det, wl, thr, rdy, clr);
        #1;
    endtask

    task automatic cmp_model(input string tag);
        chk({tag, ".valid"}, int'(win_valid), int'(m_valid));
        if (m_valid) chk({tag, ".count"}, int'(win_count), m_count);
        chk({tag, ".alarm"}, int'(alarm), int'(m_alarm));
        chk({tag, ".overrun"}, int'(overrun), int'(m_overrun));
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        enable = 0; detected = 0; win_ready = 0; clear_overrun = 0;
        window_len = '0; threshold = '0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit en; bit det; bit rdy; bit clr;
        bit e_valid; int e_count; bit e_alarm; bit e_overrun;
    } vec_t;

    vec_t vt[11];

    initial begin
        // window_len 0 (one-cycle windows), threshold 1
        vt[0]  = '{1, 0, 1, 0,   0, 0, 0, 0};  // start, nothing published yet
        vt[1]  = '{1, 1, 1, 0,   1, 1, 1, 0};
        vt[2]  = '{1, 0, 1, 0,   1, 0, 0, 0};
        vt[3]  = '{1, 1, 1, 0,   1, 1, 1, 0};
        vt[4]  = '{1, 1, 1, 0,   1, 1, 1, 0};  // publish + accept, no overrun
        vt[5]  = '{1, 0, 0, 0,   1, 1, 0, 1};  // stalled: discard, alarm still updates
        vt[6]  = '{1, 1, 0, 1,   1, 1, 1, 1};  // discard beats clear
        vt[7]  = '{1, 0, 1, 1,   1, 0, 0, 0};  // clear and fresh publish
        vt[8]  = '{0, 1, 0, 0,   1, 0, 0, 0};  // abort keeps outputs
        vt[9]  = '{0, 0, 1, 0,   0, 0, 0, 0};  // transfer empties register
        vt[10] = '{0, 1, 1, 0,   0, 0, 0, 0};  // idle ignores detected

        // reset state
        #2;
        chk("reset.valid", int'(win_valid), 0);
        chk("reset.count", int'(win_count), 0);
        chk("reset.alarm", int'(alarm), 0);
        chk("reset.overrun", int'(overrun), 0);
        do_reset();

        for (int i = 0; i < 11; i++) begin
            step(vt[i].en, vt[i].det, 0, 1, vt[i].rdy, vt[i].clr);
            $display("vec %0d: valid=%0d count=%0d alarm=%0d overrun=%0d", i,
                     win_valid, win_count, alarm, overrun);
            chk($sformatf("vec%0d.valid", i), int'(win_valid), int'(vt[i].e_valid));
            chk($sformatf("vec%0d.count", i), int'(win_count), vt[i].e_count);
            chk($sformatf("vec%0d.alarm", i), int'(alarm), int'(vt[i].e_alarm));
            chk($sformatf("vec%0d.overrun", i), int'(overrun), int'(vt[i].e_overrun));
        end

        // ---- basic count: len 8, pulses at cycles 1,4,7, threshold 2 ----
        do_reset();
        step(1, 0, 8, 2, 1, 0);
        for (int k = 0; k < 8; k++) begin
            step(1, (k == 1 || k == 4 || k == 7), 8, 2, 1, 0);
            if (k < 7) chk($sformatf("basic.early_valid%0d", k), int'(win_valid), 0);
        end
        $display("basic: valid=%0d count=%0d alarm=%0d", win_valid, win_count, alarm);
        chk("basic.valid", int'(win_valid), 1);
        chk("basic.count", int'(win_count), 3);
        chk("basic.alarm", int'(alarm), 1);
        step(1, 0, 8, 2, 1, 0);
        chk("basic.pulse_end", int'(win_valid), 0);

        // ---- saturation: len 300, detected held high ----
        do_reset();
        step(1, 0, 300, 255, 1, 0);
        for (int k = 0; k < 300; k++) step(1, 1, 300, 255, 1, 0);
        $display("sat: valid=%0d count=%0d alarm=%0d", win_valid, win_count, alarm);
        chk("sat.valid", int'(win_valid), 1);
        chk("sat.count", int'(win_count), 255);
        chk("sat.alarm", int'(alarm), 1);

        // ---- abort then full window ----
        do_reset();
        step(1, 0, 10, 0, 1, 0);
        for (int k = 0; k < 5; k++) step(1, (k % 2 == 0), 10, 0, 1, 0);
        step(0, 1, 10, 0, 1, 0);
        for (int k = 0; k < 12; k++) begin
            step(0, 1, 10, 0, 1, 0);
            chk($sformatf("abort.valid%0d", k), int'(win_valid), 0);
        end
        step(1, 0, 10, 0, 1, 0);
        for (int k = 0; k < 10; k++) step(1, (k == 3), 10, 0, 1, 0);
        $display("abort: valid=%0d count=%0d", win_valid, win_count);
        chk("abort.valid", int'(win_valid), 1);
        chk("abort.count", int'(win_count), 1);

        // ---- asynchronous reset mid-window ----
        do_reset();
        step(1, 0, 1, 0, 0, 0);
        step(1, 0, 1, 0, 0, 0);
        step(1, 1, 1, 0, 0, 0);
        chk("arst.pre_valid", int'(win_valid), 1);
        chk("arst.pre_alarm", int'(alarm), 1);
        chk("arst.pre_overrun", int'(overrun), 1);
        #2 reset = 1'b0;
        #1;
        $display("arst: valid=%0d count=%0d alarm=%0d overrun=%0d", win_valid, win_count, alarm, overrun);
        chk("arst.valid", int'(win_valid), 0);
        chk("arst.count", int'(win_count), 0);
        chk("arst.alarm", int'(alarm), 0);
        chk("arst.overrun", int'(overrun), 0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step(0, 1, 1, 0, 1, 0);
            chk($sformatf("arst.idle%0d", k), int'(win_valid), 0);
        end
        step(1, 1, 1, 0, 1, 0);
        chk("arst.start", int'(win_valid), 0);
        step(1, 1, 1, 0, 1, 0);
        chk("arst.restart_valid", int'(win_valid), 1);
        chk("arst.restart_count", int'(win_count), 1);

        // ---- randomized run against the model ----
        do_reset();
        for (int c = 0; c < 600; c++) begin
            bit en, det, rdy, clr;
            int wl, thr;
            en  = ($urandom_range(0, 19) != 0);
            det = $urandom_range(0, 1);
            rdy = ($urandom_range(0, 9) < 7);
            clr = ($urandom_range(0, 9) == 0);
            wl  = $urandom_range(0, 6);
            thr = $urandom_range(0, 4);
            step(en, det, wl, thr, rdy, clr);
            cmp_model($sformatf("rand%0d", c));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
